prism_cfg_loader: RTL and testbench

Sequencer that owns the PRISM debug write port during a bulk reconfiguration.
- On a start command it halts and resets the PRISM FSM, then streams words from an internal FIFO into consecutive debug addresses.
- It reads back each word and verifies it, then releases the FSM with the requested enable state.
- Outside a load, host bus writes pass straight through to the PRISM debug port. The block sits between the TinyQV peripheral register decode and the prism instance.

---
 rtl/prism_cfg_pkg.sv | 19 +
 rtl/prism_cfg_loader_if.sv | 15 +
 rtl/prism_cfg_fifo.sv | 53 +++++
 rtl/prism_cfg_loader.sv | 190 +++++++++++++++++++
 tb/tb_prism_cfg_loader.sv | 280 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/prism_cfg_pkg.sv
// prism_cfg_pkg: shared types and constants for the PRISM configuration loader.
//   state_t     - loader FSM states
//   ADDR_STRIDE - byte distance between consecutive debug words
//   HALT_CNT_W  - width of the halt down-counter
`timescale 1ns/1ps
package prism_cfg_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_HALT,
        ST_WRITE,
        ST_CHECK,
        ST_RELEASE
    } state_t;

    localparam int unsigned ADDR_STRIDE = 4;
    localparam int          HALT_CNT_W  = 8;

endpackage

// File: rtl/prism_cfg_loader_if.sv
// prism_cfg_loader_if: PRISM debug port bundle.
//   dbg_addr/dbg_wr/dbg_wdata - driven by the loader (master)
//   dbg_rdata                 - combinational readback from prism (slave)
`timescale 1ns/1ps
interface prism_cfg_loader_if #(
    parameter int ADDR_W = 6
);
    logic [ADDR_W-1:0] dbg_addr;
    logic              dbg_wr;
    logic [31:0]       dbg_wdata;
    logic [31:0]       dbg_rdata;

    modport master (output dbg_addr, output dbg_wr, output dbg_wdata, input dbg_rdata);
    modport slave  (input dbg_addr, input dbg_wr, input dbg_wdata, output dbg_rdata);
endinterface

// File: rtl/prism_cfg_fifo.sv
// prism_cfg_fifo: synchronous staging FIFO with flush.
//   push/push_data - write strobe and data (dropped when full unless popping)
//   pop            - removes head when not empty
//   flush          - empties the FIFO, wins over push
//   full/empty     - status, from pointers carrying one extra wrap bit
//   head           - word at the read pointer
`timescale 1ns/1ps
module prism_cfg_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    input  logic [W-1:0] push_data,
    input  logic         pop,
    input  logic         flush,
    output logic         full,
    output logic         empty,
    output logic [W-1:0] head
);
    localparam int AW = $clog2(DEPTH);

    logic [AW:0]  wr_ptr;
    logic [AW:0]  rd_ptr;
    logic [W-1:0] mem [DEPTH];
    logic         do_pop;
    logic         do_push;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_pop  = pop && !empty;
    // A pop frees the slot in the same cycle, so a push into a full FIFO is fine then.
    assign do_push = push && (!full || do_pop) && !flush;
    assign head    = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
    end
endmodule

// File: rtl/prism_cfg_loader.sv
// prism_cfg_loader: owns the PRISM debug write port during a bulk reload.
//   start/base_addr/word_count/enable_after - load request and its parameters
//   push_valid/push_data/push_ready         - staging FIFO fill port
//   host_*                                  - host debug access, forwarded while idle
//   clear_err                               - clears err and collision
//   prism                                   - debug bus towards the prism instance
//   prism_reset_o/prism_enable_o            - prism debug_reset / fsm_enable
//   busy/done/err/err_idx/collision         - status
//
// state      | meaning
// IDLE       | host passthrough, waiting for start
// HALT       | prism held in reset for HALT_CYCLES cycles
// WRITE      | write FIFO head to base+4*idx, stalls while FIFO empty
// CHECK      | compare readback with the written word
// RELEASE    | one cycle: drop reset, apply enable, pulse done
`timescale 1ns/1ps
module prism_cfg_loader
    import prism_cfg_pkg::*;
#(
    parameter int FIFO_DEPTH  = 4,
    parameter int HALT_CYCLES = 2,
    parameter int ADDR_W      = 6
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [4:0]        word_count,
    input  logic              enable_after,
    input  logic              push_valid,
    input  logic [31:0]       push_data,
    output logic              push_ready,
    input  logic [ADDR_W-1:0] host_addr,
    input  logic              host_wr,
    input  logic [31:0]       host_wdata,
    input  logic              host_enable,
    input  logic              host_reset,
    input  logic              clear_err,
    prism_cfg_loader_if.master prism,
    output logic              prism_reset_o,
    output logic              prism_enable_o,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [4:0]        err_idx,
    output logic              collision
);
    state_t                state;
    logic [ADDR_W-1:0]     base_q;
    logic [4:0]            count_q;
    logic                  en_q;
    logic                  abort_q;
    logic [4:0]            idx;
    logic [HALT_CNT_W-1:0] halt_cnt;
    logic [31:0]           wdata_q;
    logic [ADDR_W-1:0]     wr_addr;
    logic                  fifo_full;
    logic                  fifo_empty;
    logic [31:0]           fifo_head;
    logic                  fifo_pop;
    logic                  mismatch;

    assign wr_addr    = base_q + ADDR_W'(32'(idx) * ADDR_STRIDE);
    assign fifo_pop   = (state == ST_WRITE) && !fifo_empty;
    assign mismatch   = (state == ST_CHECK) && (prism.dbg_rdata != wdata_q);
    assign push_ready = !fifo_full;

    prism_cfg_fifo #(.DEPTH(FIFO_DEPTH), .W(32)) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push_valid),
        .push_data (push_data),
        .pop       (fifo_pop),
        .flush     (mismatch),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .head      (fifo_head)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            base_q    <= '0;
            count_q   <= '0;
            en_q      <= 1'b0;
            abort_q   <= 1'b0;
            idx       <= '0;
            halt_cnt  <= '0;
            wdata_q   <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
            err_idx   <= '0;
            collision <= 1'b0;
        end else begin
            done <= 1'b0;
            // Set events are written after the clear so they win in the same cycle.
            if (clear_err) begin
                err       <= 1'b0;
                collision <= 1'b0;
            end
            if (host_wr && state != ST_IDLE) collision <= 1'b1;

            case (state)
                ST_IDLE: begin
                    if (start) begin
                        base_q   <= base_addr;
                        count_q  <= word_count;
                        en_q     <= enable_after;
                        idx      <= '0;
                        abort_q  <= 1'b0;
                        halt_cnt <= HALT_CNT_W'(HALT_CYCLES - 1);
                        busy     <= 1'b1;
                        if (word_count == 5'd0) begin
                            state <= ST_RELEASE;
                            done  <= 1'b1;
                        end else begin
                            state <= ST_HALT;
                        end
                    end
                end
                ST_HALT: begin
                    if (halt_cnt == '0) state <= ST_WRITE;
                    else                halt_cnt <= halt_cnt - 1'b1;
                end
                ST_WRITE: begin
                    if (!fifo_empty) begin
                        wdata_q <= fifo_head;
                        state   <= ST_CHECK;
                    end
                end
                ST_CHECK: begin
                    if (mismatch) begin
                        if (!err) err_idx <= idx;
                        err     <= 1'b1;
                        abort_q <= 1'b1;
                        state   <= ST_RELEASE;
                        done    <= 1'b1;
                    end else if (idx == count_q - 5'd1) begin
                        state <= ST_RELEASE;
                        done  <= 1'b1;
                    end else begin
                        idx   <= idx + 5'd1;
                        state <= ST_WRITE;
                    end
                end
                ST_RELEASE: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    always_comb begin
        prism.dbg_addr  = host_addr;
        prism.dbg_wr    = host_wr;
        prism.dbg_wdata = host_wdata;
        prism_reset_o   = host_reset;
        prism_enable_o  = host_enable;
        case (state)
            ST_HALT, ST_CHECK: begin
                prism.dbg_addr  = wr_addr;
                prism.dbg_wr    = 1'b0;
                prism.dbg_wdata = wdata_q;
                prism_reset_o   = 1'b1;
                prism_enable_o  = 1'b0;
            end
            ST_WRITE: begin
                prism.dbg_addr  = wr_addr;
                prism.dbg_wr    = !fifo_empty;
                prism.dbg_wdata = fifo_head;
                prism_reset_o   = 1'b1;
                prism_enable_o  = 1'b0;
            end
            ST_RELEASE: begin
                prism.dbg_addr  = wr_addr;
                prism.dbg_wr    = 1'b0;
                prism.dbg_wdata = wdata_q;
                prism_reset_o   = 1'b0;
                prism_enable_o  = en_q && !abort_q;
            end
            default: ;
        endcase
    end
endmodule

// File: tb/tb_prism_cfg_loader.sv
`timescale 1ns/1ps
module tb_prism_cfg_loader;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [5:0]  base_addr = '0;
    logic [4:0]  word_count = '0;
    logic        enable_after = 1'b0;
    logic        push_valid = 1'b0;
    logic [31:0] push_data = '0;
    logic        push_ready;
    logic [5:0]  host_addr = '0;
    logic        host_wr = 1'b0;
    logic [31:0] host_wdata = '0;
    logic        host_enable = 1'b0;
    logic        host_reset = 1'b0;
    logic        clear_err = 1'b0;
    logic        prism_reset_o;
    logic        prism_enable_o;
    logic        busy;
    logic        done;
    logic        err;
    logic [4:0]  err_idx;
    logic        collision;

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    int s_cyc = 0;

    typedef struct packed {
        logic [5:0]  a;
        logic [31:0] d;
    } wr_t;
    wr_t exp_q[$];

    // Readback model: echoes writes, optionally corrupting one word of a load.
    logic [31:0] mem [64];
    logic        corrupt_en = 1'b0;
    int          wcnt = 0;

    prism_cfg_loader_if #(.ADDR_W(6)) dbg_bus ();
    assign dbg_bus.dbg_rdata = mem[dbg_bus.dbg_addr];

    prism_cfg_loader #(.FIFO_DEPTH(4), .HALT_CYCLES(2), .ADDR_W(6)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .start          (start),
        .base_addr      (base_addr),
        .word_count     (word_count),
        .enable_after   (enable_after),
        .push_valid     (push_valid),
        .push_data      (push_data),
        .push_ready     (push_ready),
        .host_addr      (host_addr),
        .host_wr        (host_wr),
        .host_wdata     (host_wdata),
        .host_enable    (host_enable),
        .host_reset     (host_reset),
        .clear_err      (clear_err),
        .prism          (dbg_bus),
        .prism_reset_o  (prism_reset_o),
        .prism_enable_o (prism_enable_o),
        .busy           (busy),
        .done           (done),
        .err            (err),
        .err_idx        (err_idx),
        .collision      (collision)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        if (start) wcnt <= 0;
        else if (dbg_bus.dbg_wr && busy) wcnt <= wcnt + 1;
        if (dbg_bus.dbg_wr)
            mem[dbg_bus.dbg_addr] <= (corrupt_en && busy && wcnt == 1)
                                     ? (dbg_bus.dbg_wdata ^ 32'hFF) : dbg_bus.dbg_wdata;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Scoreboard: every loader write must match the next queued expectation.
    always @(negedge clk) begin
        if (rst_n && busy && dbg_bus.dbg_wr) begin
            chk("write_expected", 64'(exp_q.size() > 0), 64'd1);
            if (exp_q.size() > 0) begin
                wr_t e;
                e = exp_q.pop_front();
                chk("write_addr", 64'(dbg_bus.dbg_addr), 64'(e.a));
                chk("write_data", 64'(dbg_bus.dbg_wdata), 64'(e.d));
            end
        end
    end

    task automatic push(input logic [31:0] d);
        push_valid = 1'b1;
        push_data  = d;
        @(negedge clk);
        push_valid = 1'b0;
    endtask

    task automatic do_start(input logic [5:0] b, input logic [4:0] n, input logic en);
        base_addr    = b;
        word_count   = n;
        enable_after = en;
        start        = 1'b1;
        s_cyc        = cyc;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done();
        int lim = 0;
        while (!done && lim < 100) begin
            @(negedge clk);
            lim++;
        end
        chk("done_seen", 64'(done), 64'd1);
    endtask

    task automatic pulse_clear();
        clear_err = 1'b1;
        @(negedge clk);
        clear_err = 1'b0;
    endtask

    initial begin
        // Reset state and idle passthrough
        host_reset  = 1'b1;
        host_addr   = 6'h15;
        #12;
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_err", 64'(err), 64'd0);
        chk("rst_err_idx", 64'(err_idx), 64'd0);
        chk("rst_collision", 64'(collision), 64'd0);
        chk("rst_push_ready", 64'(push_ready), 64'd1);
        chk("idle_reset_mux", 64'(prism_reset_o), 64'd1);
        chk("idle_addr_mux", 64'(dbg_bus.dbg_addr), 64'h15);
        @(negedge clk);
        rst_n = 1'b1;
        host_reset = 1'b0;
        @(negedge clk);

        // 1: clean load of three words
        push(32'h11); push(32'h22); push(32'h33);
        exp_q.push_back({6'h08, 32'h11});
        exp_q.push_back({6'h0C, 32'h22});
        exp_q.push_back({6'h10, 32'h33});
        do_start(6'h08, 5'd3, 1'b1);
        chk("t1_busy", 64'(busy), 64'd1);
        wait_done();
        chk("t1_latency", 64'(cyc - s_cyc), 64'd9);
        chk("t1_enable", 64'(prism_enable_o), 64'd1);
        chk("t1_release_reset", 64'(prism_reset_o), 64'd0);
        chk("t1_err", 64'(err), 64'd0);
        chk("t1_drained", 64'(exp_q.size()), 64'd0);
        @(negedge clk);
        chk("t1_idle_busy", 64'(busy), 64'd0);

        // 2: readback corrupts word 1
        corrupt_en = 1'b1;
        push(32'h11); push(32'h22); push(32'h33);
        exp_q.push_back({6'h08, 32'h11});
        exp_q.push_back({6'h0C, 32'h22});
        do_start(6'h08, 5'd3, 1'b1);
        wait_done();
        chk("t2_latency", 64'(cyc - s_cyc), 64'd7);
        chk("t2_err", 64'(err), 64'd1);
        chk("t2_err_idx", 64'(err_idx), 64'd1);
        chk("t2_enable", 64'(prism_enable_o), 64'd0);
        chk("t2_drained", 64'(exp_q.size()), 64'd0);
        corrupt_en = 1'b0;
        @(negedge clk);
        pulse_clear();
        chk("t2_err_cleared", 64'(err), 64'd0);

        // 3: start on an empty FIFO (also proves the flush), fill later
        host_enable = 1'b1;
        do_start(6'h20, 5'd2, 1'b0);
        repeat (4) @(negedge clk);
        chk("t3_stall_wr", 64'(dbg_bus.dbg_wr), 64'd0);
        chk("t3_stall_busy", 64'(busy), 64'd1);
        chk("t3_stall_addr", 64'(dbg_bus.dbg_addr), 64'h20);
        chk("t3_stall_reset", 64'(prism_reset_o), 64'd1);
        exp_q.push_back({6'h20, 32'hA5A5_0001});
        exp_q.push_back({6'h24, 32'hA5A5_0002});
        push(32'hA5A5_0001); push(32'hA5A5_0002);
        wait_done();
        chk("t3_enable", 64'(prism_enable_o), 64'd0);
        chk("t3_err", 64'(err), 64'd0);
        chk("t3_drained", 64'(exp_q.size()), 64'd0);
        host_enable = 1'b0;
        @(negedge clk);

        // 4: address wrap
        push(32'hDEAD_0000); push(32'hBEEF_0001);
        exp_q.push_back({6'h3C, 32'hDEAD_0000});
        exp_q.push_back({6'h00, 32'hBEEF_0001});
        do_start(6'h3C, 5'd2, 1'b1);
        wait_done();
        chk("t4_latency", 64'(cyc - s_cyc), 64'd7);
        chk("t4_drained", 64'(exp_q.size()), 64'd0);
        @(negedge clk);

        // 5: host write during HALT
        push(32'hC0DE);
        exp_q.push_back({6'h14, 32'hC0DE});
        do_start(6'h14, 5'd1, 1'b1);
        host_wr    = 1'b1;
        host_addr  = 6'h02;
        host_wdata = 32'h1234;
        #1;
        chk("t5_no_forward", 64'(dbg_bus.dbg_wr), 64'd0);
        @(negedge clk);
        host_wr = 1'b0;
        chk("t5_collision", 64'(collision), 64'd1);
        wait_done();
        @(negedge clk);
        chk("t5_collision_sticky", 64'(collision), 64'd1);
        pulse_clear();
        chk("t5_collision_cleared", 64'(collision), 64'd0);

        // 6: overfill, fifth push dropped
        for (int i = 0; i < 5; i++) begin
            chk("t6_push_ready", 64'(push_ready), 64'(i < 4));
            push(32'h600 + 32'(i));
        end
        for (int i = 0; i < 4; i++)
            exp_q.push_back({6'(6'h30 + 6'(4 * i)), 32'h600 + 32'(i)});
        do_start(6'h30, 5'd4, 1'b1);
        wait_done();
        chk("t6_latency", 64'(cyc - s_cyc), 64'd11);
        chk("t6_drained", 64'(exp_q.size()), 64'd0);
        @(negedge clk);

        // 7: reset while stalled in WRITE; dropped word must not appear
        host_reset = 1'b1;
        do_start(6'h00, 5'd1, 1'b1);
        repeat (4) @(negedge clk);
        chk("t7_stall_wr", 64'(dbg_bus.dbg_wr), 64'd0);
        chk("t7_stall_busy", 64'(busy), 64'd1);
        host_reset = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("t7_rst_busy", 64'(busy), 64'd0);
        chk("t7_rst_prism_reset", 64'(prism_reset_o), 64'd0);
        chk("t7_rst_done", 64'(done), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // 8: reset empties a preloaded FIFO
        push(32'h71); push(32'h72); push(32'h73);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        do_start(6'h04, 5'd1, 1'b1);
        repeat (4) @(negedge clk);
        chk("t8_stall_wr", 64'(dbg_bus.dbg_wr), 64'd0);
        exp_q.push_back({6'h04, 32'h77});
        push(32'h77);
        wait_done();
        chk("t8_err", 64'(err), 64'd0);
        chk("t8_drained", 64'(exp_q.size()), 64'd0);
        @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
